// File: rtl/wb_store_buffer.sv
// In-order store buffer between writeback and the data-memory write port.
// Queues stores, drains them one at a time over a req/ack handshake, and
// forwards the youngest pending store data to matching loads.
module wb_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_sb_wr,
    input  logic [AW-1:0]            i_sb_addr,
    input  logic [DW-1:0]            i_sb_data,
    output logic                     o_sb_full,
    output logic                     o_sb_empty,
    output logic [$clog2(DEPTH):0]   o_sb_count,
    output logic                     o_mem_req,
    output logic [AW-1:0]            o_mem_addr,
    output logic [DW-1:0]            o_mem_data,
    input  logic                     i_mem_ack,
    input  logic                     i_ld_valid,
    input  logic [AW-1:0]            i_ld_addr,
    output logic                     o_ld_hit,
    output logic [DW-1:0]            o_ld_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q [DEPTH];
    logic [DW-1:0]      data_q [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_c;
    logic               pop_c;
    logic               fwd_hit_c;
    logic [DW-1:0]      fwd_data_c;

    // A full buffer refuses the push even if the head retires this same cycle.
    assign push_c = i_sb_wr & (count_q != CNT_W'(DEPTH));
    assign pop_c  = (state_q == S_REQ) & i_mem_ack;

    // Pointer, count and valid-bit bookkeeping for push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push_c) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM next state: request while entries remain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (count_q != '0) state_d = S_REQ;
            S_REQ:  if (pop_c && (count_d == '0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Drain FSM outputs: head entry is presented while requesting.
    always_comb begin
        o_mem_req  = 1'b0;
        o_mem_addr = addr_q[head_q];
        o_mem_data = data_q[head_q];
        if (state_q == S_REQ) begin
            o_mem_req = 1'b1;
        end
    end

    // State, pointers, count and valid bits with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; validity is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (push_c) begin
            addr_q[tail_q] <= i_sb_addr;
            data_q[tail_q] <= i_sb_data;
        end
    end

    // Forwarding search from oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[head_q + PTR_W'(i)] && (addr_q[head_q + PTR_W'(i)] == i_ld_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = data_q[head_q + PTR_W'(i)];
            end
        end
    end

    assign o_ld_hit   = i_ld_valid & fwd_hit_c;
    assign o_ld_data  = o_ld_hit ? fwd_data_c : '0;
    assign o_sb_count = count_q;
    assign o_sb_full  = (count_q == CNT_W'(DEPTH));
    assign o_sb_empty = (count_q == '0);

endmodule

// File: tb/tb_wb_store_buffer.sv
// Scoreboard bench for wb_store_buffer: a queue-based reference model predicts
// occupancy, request and forwarding; a monitor checks drained stores in order.
module tb_wb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   sb_wr;
    logic [AW-1:0]          sb_addr;
    logic [DW-1:0]          sb_data;
    logic                   sb_full;
    logic                   sb_empty;
    logic [$clog2(DEPTH):0] sb_count;
    logic                   mem_req;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_data;
    logic                   mem_ack;
    logic                   ld_valid;
    logic [AW-1:0]          ld_addr;
    logic                   ld_hit;
    logic [DW-1:0]          ld_data;

    st_t mdl[$];
    st_t sb_q[$];
    st_t mon_e;
    bit  mdl_req;
    bit  armed;
    int  n_checks;
    int  n_pass;

    always #5 clk = ~clk;

    wb_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_sb_wr    (sb_wr),
        .i_sb_addr  (sb_addr),
        .i_sb_data  (sb_data),
        .o_sb_full  (sb_full),
        .o_sb_empty (sb_empty),
        .o_sb_count (sb_count),
        .o_mem_req  (mem_req),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_data),
        .i_mem_ack  (mem_ack),
        .i_ld_valid (ld_valid),
        .i_ld_addr  (ld_addr),
        .o_ld_hit   (ld_hit),
        .o_ld_data  (ld_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: every accepted drain must match the oldest expected store.
    always @(negedge clk) begin
        if (armed && (rst == 1'b0) && (mem_req === 1'b1) && (mem_ack == 1'b1)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL drain_extra: got addr 0x%0h with no store expected", mem_addr);
            end else begin
                mon_e = sb_q.pop_front();
                chk("drain_addr", mem_addr, mon_e.a);
                chk("drain_data", mem_data, mon_e.d);
            end
        end
    end

    task automatic check_outputs(input bit lv, input logic [AW-1:0] la);
        bit            exp_hit;
        logic [DW-1:0] exp_d;
        exp_hit = 1'b0;
        exp_d   = '0;
        if (lv) begin
            for (int i = mdl.size() - 1; i >= 0; i--) begin
                if (mdl[i].a == la) begin
                    exp_hit = 1'b1;
                    exp_d   = mdl[i].d;
                    break;
                end
            end
        end
        chk("count",   32'(sb_count), 32'(mdl.size()));
        chk("full",    32'(sb_full),  32'(mdl.size() == DEPTH));
        chk("empty",   32'(sb_empty), 32'(mdl.size() == 0));
        chk("mem_req", 32'(mem_req),  32'(mdl_req));
        chk("ld_hit",  32'(ld_hit),   32'(exp_hit));
        chk("ld_data", ld_data,       exp_d);
    endtask

    task automatic model_update(input bit r, input bit w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input bit k);
        int  old_cnt;
        st_t e;
        if (r) begin
            mdl.delete();
            sb_q.delete();
            mdl_req = 1'b0;
        end else begin
            old_cnt = mdl.size();
            if (mdl_req && k) void'(mdl.pop_front());
            if (w && (old_cnt < DEPTH)) begin
                e.a = a;
                e.d = d;
                mdl.push_back(e);
                sb_q.push_back(e);
            end
            mdl_req = mdl_req ? (mdl.size() != 0) : (old_cnt != 0);
        end
    endtask

    // One clock of stimulus: drive, check before the edge, then advance the model.
    task automatic cyc(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit k, input bit lv, input logic [AW-1:0] la);
        rst      = r;
        sb_wr    = w;
        sb_addr  = a;
        sb_data  = d;
        mem_ack  = k;
        ld_valid = lv;
        ld_addr  = la;
        @(negedge clk);
        if (armed) check_outputs(lv, la);
        @(posedge clk);
        model_update(r, w, a, d, k);
        armed = 1'b1;
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (((mdl.size() != 0) || mdl_req) && (budget < 20)) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
            budget++;
        end
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        chk("drain_budget", 32'(budget < 20), 32'd1);
        chk("sb_left", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        n_checks = 0;
        n_pass   = 0;
        armed    = 1'b0;
        mdl_req  = 1'b0;

        // Reset, then check reset state.
        cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h0);

        // Single store round trip.
        cyc(1'b0, 1'b1, 32'h100, 32'h11, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h100);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        chk("t1_empty", 32'(sb_empty), 32'd1);

        // Fill to full, fifth push dropped.
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 32'((i + 1) << 8), 32'(32'h20 + i), 1'b0, 1'b1, 32'((i + 1) << 8));
        cyc(1'b0, 1'b1, 32'h500, 32'h55, 1'b0, 1'b1, 32'h500);
        chk("t2_full", 32'(sb_full), 32'd1);
        drain();

        // Youngest match forwarding.
        cyc(1'b0, 1'b1, 32'h200, 32'hAA, 1'b0, 1'b1, 32'h200);
        cyc(1'b0, 1'b1, 32'h200, 32'hBB, 1'b0, 1'b1, 32'h200);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h200);
        chk("t3_fwd", ld_data, 32'hBB);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h204);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h200);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h200);
        drain();

        // Full buffer with push and ack in the same cycle.
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 32'(32'h10 + 4 * i), 32'(32'h40 + i), 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h600, 32'h66, 1'b1, 1'b1, 32'h10);
        cyc(1'b0, 1'b1, 32'h700, 32'h77, 1'b0, 1'b1, 32'h600);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h700);
        drain();

        // Alternating acks across pointer wrap.
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, 32'(32'h800 + 4 * i), 32'(i), 1'(i % 2), 1'b1, 32'(32'h800 + 4 * i));
        drain();

        // Reset mid-drain with ack asserted.
        cyc(1'b0, 1'b1, 32'h900, 32'h99, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h904, 32'h9A, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h900);
        cyc(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 32'h904);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h900);
        chk("t6_hit", 32'(ld_hit), 32'd0);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h904);

        // Random traffic over a small address pool to provoke forwarding hits.
        for (int n = 0; n < 600; n++) begin
            ra = 32'($urandom_range(0, 15)) << 2;
            cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 15)) << 2, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), ra);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
